// File: rtl/picosoc_timer_pkg.sv
// Shared register map and control-bit layout for the picosoc iomem countdown timer.
package picosoc_timer_pkg;

    localparam logic [7:0] CTRL_OFS     = 8'h00;
    localparam logic [7:0] LOAD_OFS     = 8'h04;
    localparam logic [7:0] COUNT_OFS    = 8'h08;
    localparam logic [7:0] STATUS_OFS   = 8'h0C;
    localparam logic [7:0] PRESCALE_OFS = 8'h10;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] merged;
        merged = cur;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/picosoc_timer_prescaler.sv
// Free-running prescaler: one tick every prescale+1 enabled cycles, held at 0 when disabled.
module picosoc_timer_prescaler
    import picosoc_timer_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt;

    // A clear (COUNT write) suppresses the tick so the written value is not decremented.
    assign tick = en && !clear && (pcnt == prescale);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pcnt <= '0;
        end else if (!en || clear) begin
            pcnt <= '0;
        end else if (pcnt == prescale) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/picosoc_iomem_timer.sv
// iomem-bus countdown timer: one-wait-state register interface, prescaled countdown, level IRQ.
module picosoc_iomem_timer
    import picosoc_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq_out
);

    logic                  sel;
    logic                  access;
    logic                  wr;
    logic [7:0]            ofs;
    logic                  wr_ctrl;
    logic                  wr_load;
    logic                  wr_count;
    logic                  wr_status;
    logic                  wr_prescale;
    logic [2:0]            ctrl;
    logic [31:0]           load;
    logic [31:0]           count;
    logic                  expired;
    logic [PRESCALE_W-1:0] prescale;
    logic [31:0]           prescale_merged;
    logic [31:0]           read_data;
    logic                  tick;
    logic                  expire;
    logic                  status_clear;
    logic                  unused_bits;

    assign sel    = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign access = sel && !iomem_ready;
    assign wr     = access && (iomem_wstrb != 4'b0000);
    assign ofs    = {iomem_addr[7:2], 2'b00};

    assign wr_ctrl     = wr && (ofs == CTRL_OFS);
    assign wr_load     = wr && (ofs == LOAD_OFS);
    assign wr_count    = wr && (ofs == COUNT_OFS);
    assign wr_status   = wr && (ofs == STATUS_OFS);
    assign wr_prescale = wr && (ofs == PRESCALE_OFS);

    assign prescale_merged = apply_wstrb(32'(prescale), iomem_wdata, iomem_wstrb);
    assign expire          = tick && (count == 32'd1);
    assign status_clear    = wr_status && iomem_wstrb[0] && iomem_wdata[0];
    assign unused_bits     = ^{iomem_addr[1:0], prescale_merged};

    picosoc_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .resetn   (resetn),
        .en       (ctrl[CTRL_EN]),
        .clear    (wr_count),
        .prescale (prescale),
        .tick     (tick)
    );

    always_comb begin
        read_data = '0;
        case (ofs)
            CTRL_OFS:     read_data = {29'b0, ctrl};
            LOAD_OFS:     read_data = load;
            COUNT_OFS:    read_data = count;
            STATUS_OFS:   read_data = {31'b0, expired};
            PRESCALE_OFS: read_data = 32'(prescale);
            default:      read_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            irq_out     <= 1'b0;
            ctrl        <= '0;
            load        <= '0;
            count       <= '0;
            expired     <= 1'b0;
            prescale    <= '0;
        end else begin
            iomem_ready <= access;
            iomem_rdata <= access ? read_data : '0;
            irq_out     <= expired && ctrl[CTRL_IRQ_EN];

            if (wr_ctrl && iomem_wstrb[0]) begin
                ctrl <= iomem_wdata[2:0];
            end
            if (wr_load) begin
                load <= apply_wstrb(load, iomem_wdata, iomem_wstrb);
            end
            if (wr_prescale) begin
                prescale <= prescale_merged[PRESCALE_W-1:0];
            end

            // A bus write to COUNT always wins over a tick landing in the same cycle.
            if (wr_count) begin
                count <= apply_wstrb(count, iomem_wdata, iomem_wstrb);
            end else if (tick) begin
                if (count > 32'd1) begin
                    count <= count - 32'd1;
                end else if (count == 32'd1) begin
                    count <= ctrl[CTRL_AUTO_RELOAD] ? load : 32'd0;
                end else if (ctrl[CTRL_AUTO_RELOAD] && (load != 32'd0)) begin
                    count <= load;
                end
            end

            if (expire) begin
                expired <= 1'b1;
            end else if (status_clear) begin
                expired <= 1'b0;
            end
        end
    end

endmodule
